// File: rtl/g_lshifter32_seq.sv
// g_lshifter32_seq: 32-bit logical left shifter that applies one barrel stage per clock.
// The lost output flags any set bit that is pushed out above bit 31.
module g_lshifter32_seq #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIDTH-1:0]  in1,
   input  logic [STAGES-1:0] in2,
   output logic [WIDTH-1:0]  out,
   output logic              busy,
   output logic              done,
   output logic              lost
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state, state_nx;
   logic [31:0] w, w_sh, w_nx;
   logic [4:0] a;
   logic [2:0] k;
   logic l, lo, l_nx, accept, k_last;
   assign accept = start && state != SHIFT;
   assign k_last = k == 3'd4;
   assign busy = state == SHIFT;
   assign done = state == DONE;
   // Stage k shifts by 2^k; lo collects the bits that stage would push out.
   always_comb begin
      w_sh = k == 3'd0 ? {w[30:0], 1'b0} :
             k == 3'd1 ? {w[29:0], 2'b0} :
             k == 3'd2 ? {w[27:0], 4'b0} :
             k == 3'd3 ? {w[23:0], 8'b0} : {w[15:0], 16'b0};
      lo = k == 3'd0 ? w[31] :
           k == 3'd1 ? |w[31:30] :
           k == 3'd2 ? |w[31:28] :
           k == 3'd3 ? |w[31:24] : |w[31:16];
      w_nx = a[k] ? w_sh : w;
      l_nx = l | (a[k] & lo);
      state_nx = state == SHIFT ? (k_last ? DONE : SHIFT) : (start ? SHIFT : IDLE);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         w <= '0;
         a <= '0;
         l <= 1'b0;
         k <= '0;
         out <= '0;
         lost <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            w <= in1;
            a <= in2;
            l <= 1'b0;
            k <= '0;
         end else if (state == SHIFT) begin
            w <= w_nx;
            l <= l_nx;
            k <= k_last ? 3'd0 : k + 3'd1;
            if (k_last) begin
               out <= w_nx;
               lost <= l_nx;
            end
         end
      end
   end
endmodule

// File: tb/tb_g_lshifter32_seq.sv
// tb_g_lshifter32_seq: directed vectors with hand-computed results for g_lshifter32_seq.
module tb_g_lshifter32_seq;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [31:0] in1 = '0;
   logic [4:0] in2 = '0;
   logic [31:0] out;
   logic busy, done, lost;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   g_lshifter32_seq dut (
      .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
      .out(out), .busy(busy), .done(done), .lost(lost)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Counts falling edges until done is seen, bounded so a dead DUT cannot hang the run.
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 20);
   endtask

   task automatic op(input string tag, input logic [31:0] a, input logic [4:0] b,
                     input logic [31:0] eo, input logic el);
      int n;
      @(negedge clk);
      in1 = a; in2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, " busy"}, busy, 1);
      wait_done(n);
      check({tag, " latency"}, n, 5);
      check({tag, " done"}, done, 1);
      check({tag, " busy_at_done"}, busy, 0);
      check({tag, " out"}, out, eo);
      check({tag, " lost"}, lost, el);
      @(negedge clk);
      check({tag, " done_pulse"}, done, 0);
   endtask

   initial begin
      int n, cnt;
      #12;
      check("rst out", out, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst lost", lost, 0);
      @(negedge clk);
      rst = 1'b0;

      op("one_by_31", 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
      op("f00f_by_4", 32'hF000_000F, 5'd4, 32'h0000_00F0, 1'b1);

      // Async reset between edges clears outputs without a clock
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async out", out, 0);
      check("async lost", lost, 0);
      check("async busy", busy, 0);
      check("async done", done, 0);
      #1 rst = 1'b0;

      op("beef_by_0", 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0);
      op("msb_lsb_by_1", 32'h8000_0001, 5'd1, 32'h0000_0002, 1'b1);
      op("half_by_16", 32'h1234_5678, 5'd16, 32'h5678_0000, 1'b1);
      op("low_by_16", 32'h0000_FFFF, 5'd16, 32'hFFFF_0000, 1'b0);

      // Start held high: second operation is accepted straight out of DONE
      @(negedge clk);
      in1 = 32'h1; in2 = 5'd1; start = 1'b1;
      @(negedge clk);
      in2 = 5'd2;
      wait_done(n);
      check("b2b first done", done, 1);
      check("b2b first out", out, 32'h2);
      @(negedge clk);
      check("b2b re-busy", busy, 1);
      check("b2b re-done", done, 0);
      wait_done(n);
      check("b2b second done", done, 1);
      check("b2b second out", out, 32'h4);
      start = 1'b0;
      @(negedge clk);
      check("b2b idle", busy, 0);

      // Start pulsed during SHIFT is ignored
      @(negedge clk);
      in1 = 32'h3; in2 = 5'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      in1 = 32'hFFFF_FFFF; in2 = 5'd31; start = 1'b1;
      check("ign out held", out, 32'h4);
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      check("ign done", done, 1);
      check("ign out", out, 32'hC);
      check("ign lost", lost, 0);
      @(negedge clk);
      check("ign no restart", busy, 0);

      // Reset two cycles into an operation aborts it
      @(negedge clk);
      in1 = 32'hFF; in2 = 5'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1 check("abort busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("abort no done", cnt, 0);
      check("abort out", out, 0);
      op("after_abort", 32'h0000_00FF, 5'd8, 32'h0000_FF00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
